updown_sweep_ctrl: RTL and testbench
====================================

// Module: updown_sweep_ctrl
// PURPOSE
//  Sequencer for a synchronous up/down counter (ports: sync clear, enable, updown, value y).
//  Runs a programmed number of sweeps: up-only (0->HI, clear, repeat) or ping-pong (0->HI->0).
//  Observes the counter value and drives clear/enable/direction.
//  Sits between a host (start/abort/pause) and the counter datapath.
// PARAMETERS
//  WIDTH    3  counter width; cnt_val, hi
//  SWEEP_W  4  width of n_sweeps, sweep_cnt
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        asynchronous, active-low reset (0 = reset)
//  start      in   1        begin run; sampled only in IDLE
//  abort      in   1        synchronous abort of a run
//  pause      in   1        freeze counting while 1
//  mode       in   1        0 = up-only, 1 = ping-pong; latched on start
//  hi         in   WIDTH    upper sweep bound; latched on start
//  n_sweeps   in   SWEEP_W  sweeps per run; latched on start
//  cnt_val    in   WIDTH    current counter value y
//  cnt_clr    out  1        counter sync clear (to 0)
//  cnt_en     out  1        counter count enable
//  updown     out  1        1 = count up, 0 = count down
//  busy       out  1        run in progress
//  done       out  1        one-cycle pulse at end of a completed run
//  sweep_cnt  out  SWEEP_W  sweeps completed in current/last run
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, latched regs=0, sweep_cnt=0. All outputs 0 except updown=1.
//  - Outputs are Moore, decoded from state (and pause). No output lag.
//  - IDLE: start=1 -> latch mode, hi_q=(hi==0?1:hi), n_q=(n_sweeps==0?1:n_sweeps), sweep_cnt=0 -> CLEAR.
//  - CLEAR: cnt_clr=1 for exactly 1 cycle, then -> UP.
//  - UP: cnt_en=~pause, updown=1. If !pause and cnt_val==hi_q-1, the counter reaches hi_q on this edge:
//    ping-pong -> DOWN; up-only -> end-of-sweep.
//  - DOWN: cnt_en=~pause, updown=0. If !pause and cnt_val==1, the counter reaches 0 on this edge -> end-of-sweep.
//  - End-of-sweep (same edge): sweep_cnt+=1.
//    If sweep_cnt+1==n_q -> DONE.
//    Otherwise up-only -> CLEAR; ping-pong -> UP (counter is already 0).
//  - DONE: done=1, busy=0 for 1 cycle -> IDLE. Counter keeps its final value.
//  - busy=1 in CLEAR, UP, DOWN only.
//  - pause=1: state and counter frozen (cnt_en=0). No effect in IDLE, CLEAR or DONE.
//  - abort=1 in CLEAR/UP/DOWN: -> IDLE next edge.
//    No done pulse. sweep_cnt holds its value. cnt_en drops on that edge.
//    Priority: abort > pause > bound compare.
//  - start is ignored while busy or in DONE. Input changes after latch do not affect the run.
//  - Compare uses WIDTH-bit arithmetic. hi_q=2^WIDTH-1 is legal and never wraps the counter.
//  - Reset mid-run: immediate return to reset values. No done pulse.
//  - Cycles from start edge to done=1 (no pause):
//    up-only: n*(hi_q+1)+1.  ping-pong: 1+n*2*hi_q+1.
// TESTING  (bench pairs the block with a behavioural counter, WIDTH=3)
//  - rst=0 while in UP with cnt_en=1
//    -> same cycle: cnt_en=0, busy=0, updown=1, sweep_cnt=0; stays IDLE after release.
//  - up-only, hi=5, n=2, start 1 cycle
//    -> cnt_val 0..5, 0..5; done high 13 cycles after start edge; sweep_cnt=2.
//  - ping-pong, hi=7, n=1
//    -> cnt_val 0..7..0 with no wrap; updown falls when cnt_val=7; done 16 cycles after start.
//  - ping-pong, hi=3, n=2, pause=1 for 3 cycles at cnt_val=2
//    -> cnt_val held at 2; done delayed by exactly 3 cycles.
//  - abort during DOWN of sweep 2 of 3
//    -> IDLE next edge; done never pulses; sweep_cnt=1; a new start runs normally.
//  - hi=0, n=0 -> treated as 1/1: done 3 cycles after start. start while busy -> no effect.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl
//   Sequencer for an external synchronous up/down counter. Runs a programmed
//   number of sweeps, either up-only (0->hi, clear, repeat) or ping-pong
//   (0->hi->0), watching the counter value and driving clear/enable/direction.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   start      begin a run (sampled only in IDLE)
//   abort      synchronous abort of a run in progress
//   pause      freeze counting while high
//   mode       0 = up-only, 1 = ping-pong (latched on start)
//   hi         upper sweep bound (latched on start, 0 treated as 1)
//   n_sweeps   sweeps per run (latched on start, 0 treated as 1)
//   cnt_val    current counter value
//   cnt_clr    counter synchronous clear
//   cnt_en     counter enable
//   updown     counter direction, 1 = up
//   busy       run in progress (CLEAR/UP/DOWN)
//   done       one-cycle pulse at the end of a completed run
//   sweep_cnt  sweeps completed in the current/last run
// ---------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int WIDTH   = 3,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               mode,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0]   cnt_val,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               updown,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [SWEEP_W-1:0] n_q, n_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;

    logic [WIDTH-1:0]   hi_m1;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               last_sweep;

    // Compares look one step ahead: the counter lands on the bound on the
    // same edge that the state changes, so hi_q = 2^WIDTH-1 never wraps.
    assign hi_m1      = hi_q - WIDTH'(1);
    assign sweep_inc  = sweep_q + SWEEP_W'(1);
    assign last_sweep = (sweep_inc == n_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hi_d    = hi_q;
        n_d     = n_q;
        sweep_d = sweep_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    hi_d    = (hi == '0) ? WIDTH'(1) : hi;
                    n_d     = (n_sweeps == '0) ? SWEEP_W'(1) : n_sweeps;
                    sweep_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_UP;
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause && cnt_val == hi_m1) begin
                    if (mode_q) begin
                        state_d = S_DOWN;
                    end else begin
                        sweep_d = sweep_inc;
                        state_d = last_sweep ? S_DONE : S_CLEAR;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause && cnt_val == WIDTH'(1)) begin
                    // Counter is at 0 after this edge, so the next sweep
                    // can go straight up without a clear.
                    sweep_d = sweep_inc;
                    state_d = last_sweep ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            hi_q    <= '0;
            n_q     <= '0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            sweep_q <= sweep_d;
        end
    end

    assign cnt_clr   = (state_q == S_CLEAR);
    assign cnt_en    = ((state_q == S_UP) || (state_q == S_DOWN)) && !pause;
    assign updown    = (state_q != S_DOWN);
    assign busy      = (state_q == S_CLEAR) || (state_q == S_UP) || (state_q == S_DOWN);
    assign done      = (state_q == S_DONE);
    assign sweep_cnt = sweep_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//   Pairs updown_sweep_ctrl with a behavioural counter. Each run is checked
//   against an expected per-cycle schedule (phase, counter value, sweeps
//   completed) built from the sweep rules, plus the closed-form done latency.
// ---------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, pause = 1'b0, mode = 1'b0;
    logic [2:0] hi = '0;
    logic [3:0] n_sweeps = '0;
    logic [2:0] cnt_val = '0;
    logic       cnt_clr, cnt_en, updown, busy, done;
    logic [3:0] sweep_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    updown_sweep_ctrl #(.WIDTH(3), .SWEEP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .mode(mode), .hi(hi), .n_sweeps(n_sweeps), .cnt_val(cnt_val),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .updown(updown), .busy(busy),
        .done(done), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural counter driven by the controller
    always @(posedge clk) begin
        if (cnt_clr)     cnt_val <= 3'd0;
        else if (cnt_en) cnt_val <= updown ? cnt_val + 3'd1 : cnt_val - 3'd1;
    end

    // ph: 0 = clear, 1 = up, 2 = down, 3 = done; val < 0 means don't care
    typedef struct {
        int ph;
        int val;
        int sw;
    } ent_t;
    ent_t sched[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int sw);
        chk(tag, {27'd0, cnt_clr, cnt_en, updown, busy, done}, 32'b00100);
        chk({tag, "_sweep"}, {28'd0, sweep_cnt}, sw);
    endtask

    task automatic build(input int m, input int hq, input int nq);
        sched.delete();
        sched.push_back('{0, -1, 0});
        for (int s = 0; s < nq; s++) begin
            for (int k = 0; k < hq; k++) sched.push_back('{1, k, s});
            if (m != 0) begin
                for (int k = hq; k >= 1; k--) sched.push_back('{2, k, s});
            end else if (s != nq - 1) begin
                sched.push_back('{0, hq, s + 1});
            end
        end
        sched.push_back('{3, (m != 0) ? 0 : hq, nq});
    endtask

    // pmode: 0 none, 1 random pause, 2 pause 3 cycles at first cnt_val==2
    task automatic run(input int m, input int hi_in, input int n_in,
                       input int pmode, input bit noise);
        int hq, nq, exp_lat, i, cyc, first_done, paused, pause_left;
        bit did_p, counting;
        ent_t e;
        hq = (hi_in == 0) ? 1 : hi_in;
        nq = (n_in == 0) ? 1 : n_in;
        exp_lat = (m != 0) ? 1 + nq * 2 * hq + 1 : nq * (hq + 1) + 1;
        build(m, hq, nq);
        @(negedge clk);
        mode = m[0]; hi = hi_in[2:0]; n_sweeps = n_in[3:0]; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        i = 0; cyc = 0; first_done = -1; paused = 0; pause_left = 0; did_p = 0;
        while (i < sched.size()) begin
            @(negedge clk);
            cyc++;
            e = sched[i];
            counting = (e.ph == 1) || (e.ph == 2);
            if (pmode == 1) begin
                pause = ($urandom_range(0, 3) == 0);
            end else if (pmode == 2) begin
                if (!did_p && counting && e.val == 2) begin
                    pause_left = 3;
                    did_p = 1;
                end
                pause = (pause_left > 0);
                if (pause_left > 0) pause_left--;
            end else begin
                pause = 1'b0;
            end
            if (noise) begin
                mode = 1'($urandom); hi = 3'($urandom); n_sweeps = 4'($urandom);
                start = (e.ph != 3) && ($urandom_range(0, 1) == 1);
            end
            #1;
            if (done === 1'b1 && first_done < 0) first_done = cyc;
            chk("outputs", {27'd0, cnt_clr, cnt_en, updown, busy, done},
                {27'd0, e.ph == 0, counting && !pause, e.ph != 2, e.ph != 3, e.ph == 3});
            if (e.val >= 0) chk("cnt_val", {29'd0, cnt_val}, e.val);
            chk("sweep_cnt", {28'd0, sweep_cnt}, e.sw);
            if (counting && pause) paused++;
            else i++;
        end
        pause = 1'b0; start = 1'b0;
        chk("done_latency", first_done, exp_lat + paused);
        @(negedge clk); #1;
        chk_idle("idle_after_run", nq);
    endtask

    initial begin
        int found;
        #2 rst = 1'b0;
        #1;
        chk_idle("reset", 0);
        @(negedge clk) rst = 1'b1;

        // Directed runs
        run(0, 5, 2, 0, 0);   // up-only: done at 13
        run(1, 7, 1, 0, 0);   // ping-pong full range: done at 16, no wrap
        run(1, 3, 2, 2, 0);   // pause 3 cycles at cnt_val 2
        run(0, 0, 0, 0, 1);   // hi=0/n=0 -> 1/1, start noise while busy

        // Abort during DOWN of sweep 2 of 3
        @(negedge clk);
        mode = 1'b1; hi = 3'd3; n_sweeps = 4'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (sweep_cnt == 4'd1 && busy && !updown) begin
                found = 1;
                break;
            end
        end
        chk("abort_reach_down", found, 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk_idle("abort_idle", 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("abort_no_done", {30'd0, done, busy}, 0);
        end
        run(1, 2, 2, 0, 0);   // normal run after abort

        // Async reset mid-run while counting up
        @(negedge clk);
        mode = 1'b0; hi = 3'd7; n_sweeps = 4'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (busy && cnt_en && updown && sweep_cnt == 4'd1) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_up", found, 1);
        rst = 1'b0;
        #1;
        chk_idle("rst_midrun", 0);
        @(negedge clk); @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk_idle("rst_stay_idle", 0);
        end

        // Randomized runs with random pause and input noise
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 4), 1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
